rf_rename_mp: RTL and testbench



---
 rtl/rf_rename_mp_pkg.sv | 9 +
 rtl/rf_read_port.sv | 73 +++++++
 rtl/rf_rename_mp.sv | 131 +++++++++++++
 tb/tb_rf_rename_mp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_rename_mp_pkg.sv
// Shared configuration for the rename-tracking register file.
// Bypass forwarding is selected by defining RF_BYPASS_EN at build time.
package rf_rename_mp_pkg;

    localparam int unsigned ROB_SIZE_BIT = 4;
    localparam int unsigned RF_NREG_DEF  = 32;
    localparam int unsigned RF_XLEN_DEF  = 32;

endpackage

// File: rtl/rf_read_port.sv
// One source-operand lookup port; register 0 always reads as idle zero.
// With RF_BYPASS_EN defined, same-cycle rename/commit/flush are forwarded.
module rf_read_port
    import rf_rename_mp_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN_DEF,
    parameter int unsigned NREG  = RF_NREG_DEF,
    parameter int unsigned TAG_W = ROB_SIZE_BIT,
    parameter int unsigned NCMT  = 2,
    localparam int unsigned RW   = $clog2(NREG)
) (
    input  logic [RW-1:0]         rd_id_i,
    input  logic [XLEN-1:0]       st_val_i,
    input  logic [TAG_W-1:0]      st_tag_i,
    input  logic                  st_busy_i,
    input  logic                  rdy_i,
    input  logic                  flush_i,
    input  logic                  ren_valid_i,
    input  logic [RW-1:0]         ren_rd_i,
    input  logic [TAG_W-1:0]      ren_tag_i,
    input  logic [NCMT-1:0]       cmt_valid_i,
    input  logic [NCMT*RW-1:0]    cmt_rd_i,
    input  logic [NCMT*TAG_W-1:0] cmt_tag_i,
    input  logic [NCMT*XLEN-1:0]  cmt_val_i,
    output logic [XLEN-1:0]       val_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  busy_o
);

    logic [XLEN-1:0]  val;
    logic [TAG_W-1:0] tag;
    logic             busy;

`ifdef RF_BYPASS_EN
    logic cmt_clr;

    // Lanes scanned oldest first so the youngest matching lane wins.
    always_comb begin
        val     = st_val_i;
        tag     = st_tag_i;
        busy    = st_busy_i;
        cmt_clr = 1'b0;
        if (rdy_i) begin
            for (int i = 0; i < NCMT; i++) begin
                if (cmt_valid_i[i] && (cmt_rd_i[i*RW +: RW] == rd_id_i)) begin
                    val     = cmt_val_i[i*XLEN +: XLEN];
                    cmt_clr = (cmt_tag_i[i*TAG_W +: TAG_W] == st_tag_i);
                end
            end
            if (flush_i || cmt_clr) begin
                busy = 1'b0;
            end
            if (ren_valid_i && !flush_i && (ren_rd_i == rd_id_i)) begin
                busy = 1'b1;
                tag  = ren_tag_i;
            end
        end
    end
`else
    logic unused_bypass;

    assign unused_bypass = ^{rdy_i, flush_i, ren_valid_i, ren_rd_i, ren_tag_i,
                             cmt_valid_i, cmt_rd_i, cmt_tag_i, cmt_val_i};
    assign val  = st_val_i;
    assign tag  = st_tag_i;
    assign busy = st_busy_i;
`endif

    assign val_o  = (rd_id_i == '0) ? '0 : val;
    assign tag_o  = (rd_id_i == '0) ? '0 : tag;
    assign busy_o = (rd_id_i != '0) && busy;

endmodule

// File: rtl/rf_rename_mp.sv
// Architectural register file with per-register rename tag and busy tracking.
// Read-port forwarding is enabled by RF_BYPASS_EN (see rf_read_port).
module rf_rename_mp
    import rf_rename_mp_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN_DEF,
    parameter int unsigned NREG  = RF_NREG_DEF,
    parameter int unsigned TAG_W = ROB_SIZE_BIT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NCMT  = 2,
    localparam int unsigned RW   = $clog2(NREG),
    localparam int unsigned CW   = RW + 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  ren_valid_in,
    input  logic [RW-1:0]         ren_rd_in,
    input  logic [TAG_W-1:0]      ren_tag_in,
    input  logic [NCMT-1:0]       cmt_valid_in,
    input  logic [NCMT*RW-1:0]    cmt_rd_in,
    input  logic [NCMT*TAG_W-1:0] cmt_tag_in,
    input  logic [NCMT*XLEN-1:0]  cmt_val_in,
    input  logic [NRD*RW-1:0]     rd_id_in,
    output logic [NRD*XLEN-1:0]   rd_val_out,
    output logic [NRD*TAG_W-1:0]  rd_tag_out,
    output logic [NRD-1:0]        rd_busy_out,
    output logic [CW-1:0]         busy_cnt_out
);

    logic [XLEN-1:0]  val_q [NREG];
    logic [XLEN-1:0]  val_d [NREG];
    logic [TAG_W-1:0] dep_q [NREG];
    logic [TAG_W-1:0] dep_d [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [CW-1:0]    busy_cnt_q, busy_cnt_d;
    logic [NCMT-1:0]  cmt_last;

    // A lane may clear busy only if no younger valid lane targets the same register.
    always_comb begin
        cmt_last = '0;
        for (int i = 0; i < NCMT; i++) begin
            cmt_last[i] = cmt_valid_in[i] && (cmt_rd_in[i*RW +: RW] != '0);
            for (int j = i + 1; j < NCMT; j++) begin
                if (cmt_valid_in[j] && (cmt_rd_in[j*RW +: RW] == cmt_rd_in[i*RW +: RW])) begin
                    cmt_last[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [RW-1:0] rd;
        val_d      = val_q;
        dep_d      = dep_q;
        busy_d     = busy_q;
        busy_cnt_d = '0;
        rd         = '0;
        for (int i = 0; i < NCMT; i++) begin
            rd = cmt_rd_in[i*RW +: RW];
            if (cmt_valid_in[i] && (rd != '0)) begin
                val_d[rd] = cmt_val_in[i*XLEN +: XLEN];
            end
            if (cmt_last[i] && (dep_q[rd] == cmt_tag_in[i*TAG_W +: TAG_W])) begin
                busy_d[rd] = 1'b0;
            end
        end
        if (flush_in) begin
            busy_d = '0;
            for (int r = 0; r < NREG; r++) begin
                dep_d[r] = '0;
            end
        end else if (ren_valid_in && (ren_rd_in != '0)) begin
            dep_d[ren_rd_in]  = ren_tag_in;
            busy_d[ren_rd_in] = 1'b1;
        end
        busy_d[0] = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r] <= '0;
                dep_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else if (rdy_in) begin
            val_q      <= val_d;
            dep_q      <= dep_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_out = busy_cnt_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [RW-1:0] id;
        assign id = rd_id_in[p*RW +: RW];

        rf_read_port #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .TAG_W (TAG_W),
            .NCMT  (NCMT)
        ) u_rd_port (
            .rd_id_i     (id),
            .st_val_i    (val_q[id]),
            .st_tag_i    (dep_q[id]),
            .st_busy_i   (busy_q[id]),
            .rdy_i       (rdy_in),
            .flush_i     (flush_in),
            .ren_valid_i (ren_valid_in),
            .ren_rd_i    (ren_rd_in),
            .ren_tag_i   (ren_tag_in),
            .cmt_valid_i (cmt_valid_in),
            .cmt_rd_i    (cmt_rd_in),
            .cmt_tag_i   (cmt_tag_in),
            .cmt_val_i   (cmt_val_in),
            .val_o       (rd_val_out[p*XLEN +: XLEN]),
            .tag_o       (rd_tag_out[p*TAG_W +: TAG_W]),
            .busy_o      (rd_busy_out[p])
        );
    end

endmodule

// File: tb/tb_rf_rename_mp.sv
// Directed and randomized checks of rf_rename_mp against a per-register reference model.
// The model follows RF_BYPASS_EN the same way the build does.
module tb_rf_rename_mp;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 4;
    localparam int NRD   = 2;
    localparam int NCMT  = 2;
    localparam int RW    = 5;
    localparam int CW    = 6;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  rdy_in, flush_in, ren_valid_in;
    logic [RW-1:0]         ren_rd_in;
    logic [TAG_W-1:0]      ren_tag_in;
    logic [NCMT-1:0]       cmt_valid_in;
    logic [NCMT*RW-1:0]    cmt_rd_in;
    logic [NCMT*TAG_W-1:0] cmt_tag_in;
    logic [NCMT*XLEN-1:0]  cmt_val_in;
    logic [NRD*RW-1:0]     rd_id_in;
    logic [NRD*XLEN-1:0]   rd_val_out;
    logic [NRD*TAG_W-1:0]  rd_tag_out;
    logic [NRD-1:0]        rd_busy_out;
    logic [CW-1:0]         busy_cnt_out;

    rf_rename_mp #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .TAG_W (TAG_W),
        .NRD   (NRD),
        .NCMT  (NCMT)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .ren_valid_in (ren_valid_in),
        .ren_rd_in    (ren_rd_in),
        .ren_tag_in   (ren_tag_in),
        .cmt_valid_in (cmt_valid_in),
        .cmt_rd_in    (cmt_rd_in),
        .cmt_tag_in   (cmt_tag_in),
        .cmt_val_in   (cmt_val_in),
        .rd_id_in     (rd_id_in),
        .rd_val_out   (rd_val_out),
        .rd_tag_out   (rd_tag_out),
        .rd_busy_out  (rd_busy_out),
        .busy_cnt_out (busy_cnt_out)
    );

    initial forever #5 clk = ~clk;

    logic [XLEN-1:0]  m_val  [NREG];
    logic [TAG_W-1:0] m_dep  [NREG];
    bit               m_busy [NREG];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    function automatic int youngest_lane(input int r);
        int y = -1;
        for (int i = 0; i < NCMT; i++)
            if (cmt_valid_in[i] && int'(cmt_rd_in[i*RW +: RW]) == r) y = i;
        return y;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_val[r] = '0; m_dep[r] = '0; m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (!rdy_in) return;
        for (int r = 1; r < NREG; r++) begin
            int y = youngest_lane(r);
            if (y >= 0) begin
                m_val[r] = cmt_val_in[y*XLEN +: XLEN];
                if (cmt_tag_in[y*TAG_W +: TAG_W] == m_dep[r]) m_busy[r] = 1'b0;
            end
        end
        if (flush_in) begin
            for (int r = 0; r < NREG; r++) begin
                m_busy[r] = 1'b0; m_dep[r] = '0;
            end
        end else if (ren_valid_in && ren_rd_in != '0) begin
            m_busy[ren_rd_in] = 1'b1;
            m_dep[ren_rd_in]  = ren_tag_in;
        end
    endtask

    task automatic check_reads();
        for (int p = 0; p < NRD; p++) begin
            int               r;
            logic [XLEN-1:0]  ev;
            logic [TAG_W-1:0] et;
            bit               eb;
            r  = int'(rd_id_in[p*RW +: RW]);
            ev = m_val[r]; et = m_dep[r]; eb = m_busy[r];
`ifdef RF_BYPASS_EN
            if (rdy_in && r != 0) begin
                int y = youngest_lane(r);
                if (y >= 0) ev = cmt_val_in[y*XLEN +: XLEN];
                if (flush_in || (y >= 0 && cmt_tag_in[y*TAG_W +: TAG_W] == m_dep[r])) eb = 1'b0;
                if (ren_valid_in && !flush_in && int'(ren_rd_in) == r) begin
                    eb = 1'b1; et = ren_tag_in;
                end
            end
`endif
            if (r == 0) begin
                ev = '0; et = '0; eb = 1'b0;
            end
            check($sformatf("port%0d val x%0d", p, r), 64'(rd_val_out[p*XLEN +: XLEN]), 64'(ev));
            check($sformatf("port%0d busy x%0d", p, r), 64'(rd_busy_out[p]), 64'(eb));
            if (eb) check($sformatf("port%0d tag x%0d", p, r), 64'(rd_tag_out[p*TAG_W +: TAG_W]),
                          64'(et));
        end
        check("busy_cnt", 64'(busy_cnt_out), 64'(m_count()));
    endtask

    // Called just after a falling edge with inputs driven.
    task automatic run_cycle();
        #1;
        check_reads();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rdy_in = 1'b1; flush_in = 1'b0; ren_valid_in = 1'b0; ren_rd_in = '0; ren_tag_in = '0;
        cmt_valid_in = '0; cmt_rd_in = '0; cmt_tag_in = '0; cmt_val_in = '0; rd_id_in = '0;
    endtask

    task automatic ren(input int rd, input int tag);
        ren_valid_in = 1'b1; ren_rd_in = RW'(rd); ren_tag_in = TAG_W'(tag);
    endtask

    task automatic cmt(input int lane, input int rd, input int tag, input int val);
        cmt_valid_in[lane]          = 1'b1;
        cmt_rd_in[lane*RW +: RW]     = RW'(rd);
        cmt_tag_in[lane*TAG_W +: TAG_W] = TAG_W'(tag);
        cmt_val_in[lane*XLEN +: XLEN]  = XLEN'(val);
    endtask

    task automatic peek(input string name, input int r, input int ev, input bit eb, input int et);
        idle();
        rd_id_in[RW-1:0] = RW'(r);
        #1;
        check({name, " val"}, 64'(rd_val_out[XLEN-1:0]), 64'(ev));
        check({name, " busy"}, 64'(rd_busy_out[0]), 64'(eb));
        if (eb) check({name, " tag"}, 64'(rd_tag_out[TAG_W-1:0]), 64'(et));
    endtask

    task automatic rand_inputs();
        rdy_in       = ($urandom_range(0, 7) != 0);
        flush_in     = ($urandom_range(0, 24) == 0);
        ren_valid_in = 1'($urandom_range(0, 1));
        ren_rd_in    = RW'($urandom_range(0, 7));
        ren_tag_in   = TAG_W'($urandom);
        for (int i = 0; i < NCMT; i++) begin
            int rd = $urandom_range(0, 7);
            cmt_valid_in[i]          = 1'($urandom_range(0, 1));
            cmt_rd_in[i*RW +: RW]     = RW'(rd);
            cmt_tag_in[i*TAG_W +: TAG_W] = ($urandom_range(0, 1) != 0) ? m_dep[rd] : TAG_W'($urandom);
            cmt_val_in[i*XLEN +: XLEN]  = XLEN'($urandom);
        end
        for (int p = 0; p < NRD; p++)
            rd_id_in[p*RW +: RW] = ($urandom_range(0, 2) == 0) ? ren_rd_in : RW'($urandom_range(0, 7));
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        peek("reset x5", 5, 0, 1'b0, 0);
        check("reset busy_cnt", 64'(busy_cnt_out), 64'd0);

        idle(); ren(3, 2); run_cycle();
        check("cnt after rename x3", 64'(busy_cnt_out), 64'd1);
        idle(); cmt(0, 3, 2, 32'hDEAD); run_cycle();
        peek("commit x3", 3, 32'hDEAD, 1'b0, 0);
        check("cnt after commit x3", 64'(busy_cnt_out), 64'd0);

        idle(); ren(3, 2); run_cycle();
        idle(); ren(3, 5); run_cycle();
        idle(); cmt(0, 3, 2, 7); run_cycle();
        peek("stale commit x3", 3, 7, 1'b1, 5);

        idle(); ren(4, 3); run_cycle();
        idle(); cmt(0, 4, 1, 1); cmt(1, 4, 3, 9); run_cycle();
        peek("two lanes x4 dep3", 4, 9, 1'b0, 0);
        idle(); ren(4, 1); run_cycle();
        idle(); cmt(0, 4, 1, 1); cmt(1, 4, 3, 9); run_cycle();
        peek("two lanes x4 dep1", 4, 9, 1'b1, 1);

        idle(); ren(6, 4); run_cycle();
        idle(); ren(6, 8); cmt(0, 6, 4, 32'h66); rd_id_in[2*RW-1:RW] = RW'(6);
        #1;
`ifdef RF_BYPASS_EN
        check("x6 bypass val", 64'(rd_val_out[2*XLEN-1:XLEN]), 64'h66);
        check("x6 bypass busy", 64'(rd_busy_out[1]), 64'd1);
        check("x6 bypass tag", 64'(rd_tag_out[2*TAG_W-1:TAG_W]), 64'd8);
`else
        check("x6 held val", 64'(rd_val_out[2*XLEN-1:XLEN]), 64'h0);
        check("x6 held busy", 64'(rd_busy_out[1]), 64'd1);
        check("x6 held tag", 64'(rd_tag_out[2*TAG_W-1:TAG_W]), 64'd4);
`endif
        run_cycle();
        peek("rename beats clear x6", 6, 32'h66, 1'b1, 8);
        check("cnt three busy", 64'(busy_cnt_out), 64'd3);

        idle(); flush_in = 1'b1; cmt(0, 7, 0, 32'h11); ren(9, 3); run_cycle();
        check("cnt after flush", 64'(busy_cnt_out), 64'd0);
        peek("flush commit x7", 7, 32'h11, 1'b0, 0);
        peek("flush drops rename x9", 9, 0, 1'b0, 0);
        peek("flush clears x3", 3, 7, 1'b0, 0);

        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            run_cycle();
        end

        idle(); rd_id_in = {RW'(7), RW'(3)};
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset port0 val", 64'(rd_val_out[XLEN-1:0]), 64'd0);
        check("async reset port1 val", 64'(rd_val_out[2*XLEN-1:XLEN]), 64'd0);
        check("async reset busy", 64'(rd_busy_out), 64'd0);
        check("async reset cnt", 64'(busy_cnt_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 100; n++) begin
            rand_inputs();
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
